// File: rtl/cpu_tick_pkg.sv
// rtl/cpu_tick_pkg.sv - Shared types, defaults and reset values for the CPU tick generator.
package cpu_tick_pkg;

   localparam int DIV_WIDTH_DEF = 16;
   localparam int CNT_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      HALTED = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2
   } tick_state_e;

   localparam tick_state_e STATE_RST   = HALTED;
   localparam logic        TICK_RST    = 1'b0;
   localparam logic        RUNNING_RST = 1'b0;
   localparam logic        BP_HIT_RST  = 1'b0;

   function automatic logic state_active(input tick_state_e s);
      return (s == RUN) || (s == STEP);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - Tick divider: counts up to div_ratio, flags expiry, held at zero while idle.
module tick_divider
   import cpu_tick_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold,
   input  logic [DIV_WIDTH-1:0] div_ratio,
   output logic                 expire
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   // >= rather than == so a ratio lowered below the count expires at once
   always_comb begin
      expire = 1'b0;
      cnt_d  = cnt_q;
      if (hold) begin
         cnt_d = '0;
      end else if (cnt_q >= div_ratio) begin
         expire = 1'b1;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_tick_gen.sv
// rtl/cpu_tick_gen.sv - CPU state-advance enable: run/halt/step FSM, divider, tick counter.
// Optional breakpoint halt enabled by CPU_TICK_BREAKPOINT_EN.
module cpu_tick_gen
   import cpu_tick_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [DIV_WIDTH-1:0] DivRatio,
   input  logic                 Go,
   input  logic                 Halt,
   input  logic                 Step,
   input  logic                 HaltReq,
`ifdef CPU_TICK_BREAKPOINT_EN
   input  logic                 BpEnable,
   input  logic [31:0]          BpAddr,
   input  logic [31:0]          Pc,
   output logic                 BpHit,
`endif
   output logic                 Tick,
   output logic                 Running,
   output logic [CNT_WIDTH-1:0] CycleCount
);

   tick_state_e          state_q, state_d;
   logic                 tick_q, tick_d;
   logic                 running_q, running_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;

   logic stop_req;
   logic div_hold;
   logic expire;
   logic bp_stop;

   assign stop_req = Halt | HaltReq;
   assign div_hold = !state_active(state_q);

   tick_divider #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_divider (
      .clk       (Clock),
      .reset     (Reset),
      .hold      (div_hold),
      .div_ratio (DivRatio),
      .expire    (expire)
   );

`ifdef CPU_TICK_BREAKPOINT_EN
   logic skip_q, skip_d;
   logic bp_hit_q, bp_hit_d;
   logic start;

   assign start   = (state_q == HALTED) && !stop_req && (Go || Step);
   // skip_q lets a resume move off the PC it stopped on
   assign bp_stop = (state_q == RUN) && expire && BpEnable && (Pc == BpAddr) && !skip_q;

   always_comb begin
      skip_d   = skip_q;
      bp_hit_d = bp_hit_q;
      if (start) begin
         skip_d   = 1'b1;
         bp_hit_d = 1'b0;
      end else begin
         if (state_active(state_q) && expire) begin
            skip_d = 1'b0;
         end
         if (bp_stop && !stop_req) begin
            bp_hit_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         skip_q   <= 1'b0;
         bp_hit_q <= BP_HIT_RST;
      end else begin
         skip_q   <= skip_d;
         bp_hit_q <= bp_hit_d;
      end
   end

   assign BpHit = bp_hit_q;
`else
   assign bp_stop = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = 1'b0;
      case (state_q)
         HALTED: begin
            if (stop_req) begin
               state_d = HALTED;
            end else if (Go) begin
               state_d = RUN;
            end else if (Step) begin
               state_d = STEP;
            end
         end
         RUN: begin
            if (stop_req || bp_stop) begin
               state_d = HALTED;
            end else if (expire) begin
               tick_d = 1'b1;
            end
         end
         STEP: begin
            if (stop_req) begin
               state_d = HALTED;
            end else if (expire) begin
               tick_d  = 1'b1;
               state_d = HALTED;
            end
         end
         default: begin
            state_d = STATE_RST;
         end
      endcase
      running_d     = state_active(state_d);
      cycle_count_d = cycle_count_q + CNT_WIDTH'(tick_d);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q       <= STATE_RST;
         tick_q        <= TICK_RST;
         running_q     <= RUNNING_RST;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         running_q     <= running_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign Tick       = tick_q;
   assign Running    = running_q;
   assign CycleCount = cycle_count_q;

endmodule

// File: tb/tb_cpu_tick_gen.sv
// tb/tb_cpu_tick_gen.sv - Directed self-checking bench for cpu_tick_gen (breakpoint steps with CPU_TICK_BREAKPOINT_EN).
module tb_cpu_tick_gen;

   logic        Clock = 1'b0;
   logic        Reset, Go, Halt, Step, HaltReq;
   logic [15:0] DivRatio;
   logic        Tick, Running;
   logic [31:0] CycleCount;
   logic        tick_s, running_s;
   logic [7:0]  count_s;
   int          checks = 0;
   int          failures = 0;

   always #5 Clock = ~Clock;

`ifdef CPU_TICK_BREAKPOINT_EN
   logic        BpEnable;
   logic [31:0] BpAddr, Pc;
   logic        BpHit, bp_hit_s;
`endif

   cpu_tick_gen dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .DivRatio   (DivRatio),
      .Go         (Go),
      .Halt       (Halt),
      .Step       (Step),
      .HaltReq    (HaltReq),
`ifdef CPU_TICK_BREAKPOINT_EN
      .BpEnable   (BpEnable),
      .BpAddr     (BpAddr),
      .Pc         (Pc),
      .BpHit      (BpHit),
`endif
      .Tick       (Tick),
      .Running    (Running),
      .CycleCount (CycleCount)
   );

   // narrow counter copy so the wrap can be reached in a few hundred cycles
   cpu_tick_gen #(.DIV_WIDTH(16), .CNT_WIDTH(8)) dut_w (
      .Clock      (Clock),
      .Reset      (Reset),
      .DivRatio   (DivRatio),
      .Go         (Go),
      .Halt       (Halt),
      .Step       (Step),
      .HaltReq    (HaltReq),
`ifdef CPU_TICK_BREAKPOINT_EN
      .BpEnable   (BpEnable),
      .BpAddr     (BpAddr),
      .Pc         (Pc),
      .BpHit      (bp_hit_s),
`endif
      .Tick       (tick_s),
      .Running    (running_s),
      .CycleCount (count_s)
   );

   task automatic clk(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      clk(1);
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Go = 1'b0; Halt = 1'b0; Step = 1'b0; HaltReq = 1'b0; DivRatio = 16'd0;
`ifdef CPU_TICK_BREAKPOINT_EN
      BpEnable = 1'b0; BpAddr = 32'h0; Pc = 32'h0;
`endif
      clk(2);
      chk("rst_tick", Tick, 1'b0);
      chk("rst_running", Running, 1'b0);
      chk("rst_count", CycleCount, 32'd0);
      chk("rst_count_w", count_s, 8'd0);
      Reset = 1'b0;

      // DivRatio 0: tick every cycle from cycle 2
      Go = 1'b1; clk(1); Go = 1'b0;
      chk("d0_running_c1", Running, 1'b1);
      chk("d0_tick_c1", Tick, 1'b0);
      clk(1);
      chk("d0_tick_c2", Tick, 1'b1);
      chk("d0_count_c2", CycleCount, 32'd1);
      clk(9);
      chk("d0_tick_c11", Tick, 1'b1);
      chk("d0_count_c11", CycleCount, 32'd10);
      chk("d0_count_w_c11", count_s, 8'd10);
      Halt = 1'b1; clk(1); Halt = 1'b0;
      chk("d0_halt_tick", Tick, 1'b0);
      chk("d0_halt_running", Running, 1'b0);
      chk("d0_halt_count", CycleCount, 32'd10);

      // DivRatio 3: ticks at 5, 9, 13; halt at 12 kills tick 13
      do_reset();
      DivRatio = 16'd3;
      Go = 1'b1; clk(1); Go = 1'b0;
      clk(3);
      chk("d3_tick_c4", Tick, 1'b0);
      clk(1);
      chk("d3_tick_c5", Tick, 1'b1);
      chk("d3_count_c5", CycleCount, 32'd1);
      clk(1);
      chk("d3_tick_c6", Tick, 1'b0);
      clk(3);
      chk("d3_tick_c9", Tick, 1'b1);
      clk(3);
      chk("d3_tick_c12", Tick, 1'b0);
      Halt = 1'b1; clk(1); Halt = 1'b0;
      chk("d3_tick_c13", Tick, 1'b0);
      chk("d3_running_c13", Running, 1'b0);
      chk("d3_count_c13", CycleCount, 32'd2);

      // Step with DivRatio 2: single tick at cycle 4, second Step ignored
      do_reset();
      DivRatio = 16'd2;
      Step = 1'b1; clk(1); Step = 1'b0;
      chk("st_running_c1", Running, 1'b1);
      clk(1);
      Step = 1'b1; clk(1); Step = 1'b0;
      chk("st_tick_c3", Tick, 1'b0);
      chk("st_running_c3", Running, 1'b1);
      clk(1);
      chk("st_tick_c4", Tick, 1'b1);
      chk("st_running_c4", Running, 1'b0);
      chk("st_count_c4", CycleCount, 32'd1);
      clk(1);
      chk("st_tick_c5", Tick, 1'b0);
      clk(5);
      chk("st_tick_c10", Tick, 1'b0);
      chk("st_count_c10", CycleCount, 32'd1);

      // DivRatio lowered 100 -> 10 with counter at 50
      do_reset();
      DivRatio = 16'd100;
      Go = 1'b1; clk(1); Go = 1'b0;
      clk(50);
      chk("lr_tick_c51", Tick, 1'b0);
      DivRatio = 16'd10;
      clk(1);
      chk("lr_tick_c52", Tick, 1'b1);
      chk("lr_count_c52", CycleCount, 32'd1);
      clk(10);
      chk("lr_tick_c62", Tick, 1'b0);
      clk(1);
      chk("lr_tick_c63", Tick, 1'b1);
      clk(11);
      chk("lr_tick_c74", Tick, 1'b1);
      chk("lr_count_c74", CycleCount, 32'd3);
      Halt = 1'b1; clk(1); Halt = 1'b0;

      // HaltReq held: Go and Step have no effect
      do_reset();
      DivRatio = 16'd0;
      HaltReq = 1'b1;
      Go = 1'b1; clk(1); Go = 1'b0;
      chk("hr_running_go", Running, 1'b0);
      Step = 1'b1; clk(1); Step = 1'b0;
      clk(3);
      chk("hr_tick", Tick, 1'b0);
      chk("hr_running", Running, 1'b0);
      chk("hr_count", CycleCount, 32'd0);
      HaltReq = 1'b0;

      // counter wrap on the narrow copy, then reset mid-run at all-ones
      do_reset();
      Go = 1'b1; clk(1); Go = 1'b0;
      clk(255);
      chk("wr_count_w_ff", count_s, 8'hFF);
      chk("wr_count_255", CycleCount, 32'd255);
      clk(1);
      chk("wr_count_w_wrap", count_s, 8'h00);
      chk("wr_count_256", CycleCount, 32'd256);
      chk("wr_tick_w", tick_s, 1'b1);
      clk(255);
      chk("wr_count_w_ff2", count_s, 8'hFF);
      chk("wr_running_w", running_s, 1'b1);
      Reset = 1'b1; clk(1); Reset = 1'b0;
      chk("mr_tick", Tick, 1'b0);
      chk("mr_running", Running, 1'b0);
      chk("mr_count", CycleCount, 32'd0);
      chk("mr_tick_w", tick_s, 1'b0);
      chk("mr_running_w", running_s, 1'b0);
      chk("mr_count_w", count_s, 8'd0);

`ifdef CPU_TICK_BREAKPOINT_EN
      // breakpoint at 0x10 with DivRatio 1: ticks at 3 and 5, hit at 7
      do_reset();
      DivRatio = 16'd1;
      BpEnable = 1'b1; BpAddr = 32'h0000_0010; Pc = 32'h0;
      Go = 1'b1; clk(1); Go = 1'b0;
      clk(2);
      chk("bp_tick_c3", Tick, 1'b1);
      clk(2);
      chk("bp_tick_c5", Tick, 1'b1);
      Pc = 32'h0000_0010;
      clk(2);
      chk("bp_tick_c7", Tick, 1'b0);
      chk("bp_running_c7", Running, 1'b0);
      chk("bp_hit_c7", BpHit, 1'b1);
      chk("bp_count_c7", CycleCount, 32'd2);
      Go = 1'b1; clk(1); Go = 1'b0;
      chk("bp_hit_c8", BpHit, 1'b0);
      chk("bp_running_c8", Running, 1'b1);
      clk(2);
      chk("bp_skip_tick_c10", Tick, 1'b1);
      chk("bp_skip_count_c10", CycleCount, 32'd3);
      clk(2);
      chk("bp_rehit_tick_c12", Tick, 1'b0);
      chk("bp_rehit_c12", BpHit, 1'b1);
      chk("bp_rehit_running_c12", Running, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
